// File: rtl/bus_rx_pkg.sv
// Shared state type and default sizing for the strobed bus receiver.
package bus_rx_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_DEPTH       = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_SETTLE      = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    ACK
  } rx_state_t;

endpackage

// File: rtl/bus_rx_fifo.sv
// Small power-of-two FIFO; head is read straight from storage and holds the
// last popped word while empty.
module bus_rx_fifo
  import bus_rx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    last_ptr;
  logic [CNTW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNTW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign last_ptr = rd_ptr - AW'(1);
  assign head     = empty ? mem[last_ptr] : mem[rd_ptr];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_strobe_receiver.sv
// Receiving end of a strobed registered bus: synchronises STB_N, waits SETTLE cycles,
// captures D into a FIFO and answers with a 4-phase ACK_N. Option: BUS_STROBE_RECEIVER_PARITY_EN.
module bus_strobe_receiver
  import bus_rx_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned SETTLE      = DEF_SETTLE,
  parameter int unsigned DEPTH       = DEF_DEPTH
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] D,
  input  logic             STB_N,
  output logic             ACK_N,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  input  logic             READ,
  output logic             FULL,
  output logic             ERR,
  input  logic             CLR_ERR
`ifdef BUS_STROBE_RECEIVER_PARITY_EN
  ,
  input  logic             DP,
  output logic             PERR
`endif
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] primed_q;
  logic                   stb_s;
  logic                   stb_prev;
  logic                   fall_c;
  rx_state_t              state;
  rx_state_t              state_d;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_d;
  logic                   ack_n_d;
  logic                   err_d;
  logic                   err_set_c;
  logic                   push_c;
  logic                   empty;

  assign stb_s  = sync_q[SYNC_STAGES-1];
  assign fall_c = !stb_s && stb_prev;

  // primed_q keeps the edge detector disarmed until stb_s carries real samples,
  // so a strobe held low through reset must be seen high before it counts.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q   <= '1;
      primed_q <= '0;
      stb_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], STB_N};
      primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
      stb_prev <= primed_q[SYNC_STAGES-1] ? stb_s : 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= bus_rx_pkg::IDLE;
      cnt   <= '0;
      ACK_N <= 1'b1;
      ERR   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      ACK_N <= ack_n_d;
      ERR   <= err_d;
    end
  end

  // Handshake sequencing; a strobe released before the ack is a protocol error.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    ack_n_d   = 1'b1;
    push_c    = 1'b0;
    err_set_c = 1'b0;
    case (state)
      bus_rx_pkg::IDLE: begin
        if (fall_c) begin
          state_d = bus_rx_pkg::SETTLE;
          cnt_d   = CW'(SETTLE - 1);
        end
      end
      bus_rx_pkg::SETTLE: begin
        if (stb_s) begin
          err_set_c = 1'b1;
          state_d   = bus_rx_pkg::IDLE;
        end else if (cnt == '0) begin
          state_d = bus_rx_pkg::CAPTURE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      bus_rx_pkg::CAPTURE: begin
        if (stb_s) begin
          err_set_c = 1'b1;
          state_d   = bus_rx_pkg::IDLE;
        end else if (!FULL) begin
          push_c  = 1'b1;
          ack_n_d = 1'b0;
          state_d = bus_rx_pkg::ACK;
        end
      end
      bus_rx_pkg::ACK: begin
        if (stb_s) state_d = bus_rx_pkg::IDLE;
        else       ack_n_d = 1'b0;
      end
      default: state_d = bus_rx_pkg::IDLE;
    endcase
    if (CLR_ERR)        err_d = 1'b0;
    else if (err_set_c) err_d = 1'b1;
    else                err_d = ERR;
  end

`ifdef BUS_STROBE_RECEIVER_PARITY_EN
  // Odd parity over {D,DP}; a bad word is still stored and acknowledged.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                    PERR <= 1'b0;
    else if (CLR_ERR)                PERR <= 1'b0;
    else if (push_c && !(^{D, DP}))  PERR <= 1'b1;
  end
`endif

  bus_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (push_c),
    .pop     (READ),
    .wdata   (D),
    .head    (Q),
    .full    (FULL),
    .empty   (empty)
  );

  assign VALID = !empty;

endmodule

// File: tb/tb_bus_strobe_receiver.sv
// Self-checking bench for bus_strobe_receiver: handshake table plus corner-case sequences.
module tb_bus_strobe_receiver;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned SETTLE      = 2;
  localparam int unsigned LAT_ACK     = SYNC_STAGES + SETTLE + 2;
  localparam int unsigned LAT_REL     = SYNC_STAGES + 1;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic [WIDTH-1:0] D;
  logic             STB_N;
  logic             ACK_N;
  logic [WIDTH-1:0] Q;
  logic             VALID;
  logic             READ;
  logic             FULL;
  logic             ERR;
  logic             CLR_ERR;
`ifdef BUS_STROBE_RECEIVER_PARITY_EN
  logic             DP;
  logic             PERR;
`endif

  int unsigned      n_vec = 0;
  int unsigned      n_bad = 0;
  logic [WIDTH-1:0] sb [$];

  typedef struct {
    logic [WIDTH-1:0] d;
    bit               rd;
    logic             exp_valid;
  } vec_t;

  vec_t tbl [4];

  always #5 CLK = ~CLK;

  bus_strobe_receiver #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .SETTLE      (SETTLE),
    .DEPTH       (DEPTH)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .D       (D),
    .STB_N   (STB_N),
    .ACK_N   (ACK_N),
    .Q       (Q),
    .VALID   (VALID),
    .READ    (READ),
    .FULL    (FULL),
    .ERR     (ERR),
    .CLR_ERR (CLR_ERR)
`ifdef BUS_STROBE_RECEIVER_PARITY_EN
    ,
    .DP      (DP),
    .PERR    (PERR)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wait_ack(input logic lvl, output int unsigned n);
    n = 0;
    while (ACK_N !== lvl && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic strobe_word(input logic [WIDTH-1:0] d, input string tag);
    int unsigned n;
    D     = d;
    STB_N = 1'b0;
    sb.push_back(d);
    wait_ack(1'b0, n);
    check($sformatf("%s_ack_lat", tag), n, LAT_ACK);
    check($sformatf("%s_valid", tag), VALID, 1'b1);
    STB_N = 1'b1;
    wait_ack(1'b1, n);
    check($sformatf("%s_rel_lat", tag), n, LAT_REL);
  endtask

  task automatic read_word(input string tag);
    logic [WIDTH-1:0] exp;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, nothing to compare", tag);
    end else begin
      exp = sb.pop_front();
      check($sformatf("%s_q", tag), Q, exp);
      check($sformatf("%s_valid", tag), VALID, 1'b1);
    end
    READ = 1'b1;
    tick();
    READ = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned      n;
    logic             seen;
    logic [WIDTH-1:0] exp;

    tbl[0] = '{d: 8'hA5, rd: 1'b1, exp_valid: 1'b0};
    tbl[1] = '{d: 8'h3C, rd: 1'b0, exp_valid: 1'b1};
    tbl[2] = '{d: 8'hFF, rd: 1'b1, exp_valid: 1'b1};
    tbl[3] = '{d: 8'h5A, rd: 1'b1, exp_valid: 1'b1};

    RESET_N = 1'b0;
    STB_N   = 1'b1;
    D       = '0;
    READ    = 1'b0;
    CLR_ERR = 1'b0;
`ifdef BUS_STROBE_RECEIVER_PARITY_EN
    DP      = 1'b0;
`endif
    repeat (3) tick();
    check("rst_ack_n", ACK_N, 1'b1);
    check("rst_valid", VALID, 1'b0);
    check("rst_full",  FULL,  1'b0);
    check("rst_err",   ERR,   1'b0);
    check("rst_q",     Q,     8'h00);
    RESET_N = 1'b1;
    repeat (4) tick();

    // basic handshakes from the table
    for (int i = 0; i < 4; i++) begin
      strobe_word(tbl[i].d, $sformatf("vec%0d", i));
      if (tbl[i].rd) read_word($sformatf("vec%0d_rd", i));
      check($sformatf("vec%0d_valid_after", i), VALID, tbl[i].exp_valid);
    end
    read_word("drain");
    check("drain_empty", VALID, 1'b0);
    check("q_hold_empty", Q, 8'h5A);

    // fill to full, fifth word stalls until a read frees a slot
    for (int i = 1; i <= 4; i++) strobe_word(WIDTH'(i), $sformatf("fill%0d", i));
    check("full_set", FULL, 1'b1);
    D     = 8'h05;
    STB_N = 1'b0;
    sb.push_back(8'h05);
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (ACK_N === 1'b0) seen = 1'b1;
    end
    check("full_stall_ack_low_seen", seen, 1'b0);
    read_word("full_rd");
    check("full_after_pop_ack_n", ACK_N, 1'b1);
    check("full_after_pop_full", FULL, 1'b0);
    tick();
    check("full_push_ack_n", ACK_N, 1'b0);
    check("full_push_full", FULL, 1'b1);
    STB_N = 1'b1;
    wait_ack(1'b1, n);
    check("full_rel_lat", n, LAT_REL);
    for (int i = 0; i < 4; i++) read_word($sformatf("full_drain%0d", i));
    check("full_drain_empty", VALID, 1'b0);

    // strobe released during settle: error, nothing stored
    STB_N = 1'b0;
    D     = 8'hEE;
    tick();
    STB_N = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (ACK_N === 1'b0) seen = 1'b1;
    end
    check("abort_ack_low_seen", seen, 1'b0);
    check("abort_err", ERR, 1'b1);
    check("abort_valid", VALID, 1'b0);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    check("abort_clr_err", ERR, 1'b0);

    // pop and push on the same edge keep count and order
    strobe_word(8'h11, "pp_a");
    strobe_word(8'h22, "pp_b");
    D     = 8'h33;
    STB_N = 1'b0;
    sb.push_back(8'h33);
    repeat (LAT_ACK - 1) tick();
    check("pp_pre_ack_n", ACK_N, 1'b1);
    exp = sb.pop_front();
    check("pp_head_q", Q, exp);
    READ = 1'b1;
    tick();
    READ = 1'b0;
    check("pp_ack_n", ACK_N, 1'b0);
    check("pp_valid", VALID, 1'b1);
    check("pp_full", FULL, 1'b0);
    STB_N = 1'b1;
    wait_ack(1'b1, n);
    check("pp_rel_lat", n, LAT_REL);
    read_word("pp_rd0");
    read_word("pp_rd1");
    check("pp_empty", VALID, 1'b0);

    // reset in the middle of a handshake with the strobe still low
    D     = 8'h44;
    STB_N = 1'b0;
    wait_ack(1'b0, n);
    check("mid_rst_ack_lat", n, LAT_ACK);
    #2 RESET_N = 1'b0;
    #1;
    check("mid_rst_ack_n", ACK_N, 1'b1);
    check("mid_rst_valid", VALID, 1'b0);
    sb.delete();
    tick();
    RESET_N = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (ACK_N === 1'b0 || VALID === 1'b1) seen = 1'b1;
    end
    check("held_low_ignored", seen, 1'b0);
    STB_N = 1'b1;
    repeat (4) tick();
    strobe_word(8'h55, "post_rst");
    read_word("post_rst_rd");

`ifdef BUS_STROBE_RECEIVER_PARITY_EN
    // odd parity over {D,DP}
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    check("par_clr", PERR, 1'b0);
    DP = 1'b0;
    strobe_word(8'h01, "par_ok");
    check("par_ok_perr", PERR, 1'b0);
    DP = 1'b0;
    strobe_word(8'h03, "par_bad");
    check("par_bad_perr", PERR, 1'b1);
    read_word("par_rd0");
    read_word("par_rd1");
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    check("par_clr2", PERR, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
